dly_tap_ctrl: RTL and testbench

Tap-load sequencer sitting directly upstream of the DDR3 PHY's VAR_LOAD IDELAYE2/ODELAYE2 delay elements. It serializes per-byte-lane tap writes and reads from the training logic onto the delay elements' CNTVALUEIN/LD/CNTVALUEOUT pins. It gates all activity on IDELAYCTRL ready. After each load it verifies that the loaded value reads back.

---
 rtl/dly_tap_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_dly_tap_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dly_tap_ctrl.sv
// Tap-load sequencer for VAR_LOAD IDELAYE2/ODELAYE2 lanes: serialises tap writes/reads,
// zero-initialises every lane after IDELAYCTRL ready, and verifies each load by readback.
module dly_tap_ctrl #(
  parameter int unsigned W      = 8,
  parameter int unsigned TAPW   = 5,
  parameter int unsigned SETTLE = 4,
  localparam int unsigned LW    = (W > 1) ? $clog2(W) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dlyctrl_rdy,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [LW-1:0]     cmd_lane,
  input  logic [TAPW-1:0]   cmd_tap,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [TAPW-1:0]   rsp_tap,
  output logic              rsp_err,
  output logic [W-1:0]      ld,
  output logic [W*TAPW-1:0] cntvaluein,
  input  logic [W*TAPW-1:0] cntvalueout,
  output logic              init_done
);

  typedef enum logic [2:0] {
    StInitWait, StInitLoad, StIdle, StLoad, StSettle, StCheck, StResp
  } state_e;

  logic [1:0]      r_rst_sync;
  logic            w_rst;
  state_e          r_state, w_state_nxt;
  logic            r_rdy_seen, w_rdy_seen_nxt;
  logic [LW-1:0]   r_lane, w_lane_nxt;
  logic [3:0]      r_cnt, w_cnt_nxt;
  logic [TAPW-1:0] r_tap, w_tap_nxt;
  logic            r_rsp_valid, w_rsp_valid_nxt;
  logic [TAPW-1:0] r_rsp_tap, w_rsp_tap_nxt;
  logic            r_rsp_err, w_rsp_err_nxt;
  logic            r_init_done, w_init_done_nxt;
  logic            r_abort, w_abort_nxt;
  logic [TAPW-1:0] r_shadow [W];
  logic [TAPW-1:0] w_out [W];
  logic            w_ld_cycle;
  logic [TAPW-1:0] w_ld_val;
  logic            w_lane_ok;
  logic            w_accept;

  // Reset asserts asynchronously but is released on a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rst_sync <= 2'b11;
    else     r_rst_sync <= {r_rst_sync[0], 1'b0};
  end
  assign w_rst = r_rst_sync[1];

  always_comb begin
    for (int unsigned i = 0; i < W; i++) w_out[i] = cntvalueout[i*TAPW +: TAPW];
  end

  assign w_lane_ok = 32'(cmd_lane) < W;
  assign cmd_ready = (r_state == StIdle) && !r_rsp_valid && dlyctrl_rdy;
  assign w_accept  = cmd_valid && cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_tap   = r_rsp_tap;
  assign rsp_err   = r_rsp_err;
  assign init_done = r_init_done;

  always_comb begin
    w_state_nxt      = r_state;
    w_rdy_seen_nxt   = r_rdy_seen;
    w_lane_nxt       = r_lane;
    w_cnt_nxt        = r_cnt;
    w_tap_nxt        = r_tap;
    w_rsp_valid_nxt  = r_rsp_valid;
    w_rsp_tap_nxt    = r_rsp_tap;
    w_rsp_err_nxt    = r_rsp_err;
    w_init_done_nxt  = r_init_done;
    w_abort_nxt      = r_abort;
    w_ld_cycle       = 1'b0;
    w_ld_val         = '0;
    unique case (r_state)
      StInitWait: begin
        if (!dlyctrl_rdy) begin
          w_rdy_seen_nxt = 1'b0;
        end else if (r_rdy_seen) begin
          w_rdy_seen_nxt = 1'b0;
          w_state_nxt    = StInitLoad;
          w_lane_nxt     = '0;
          w_cnt_nxt      = '0;
        end else begin
          w_rdy_seen_nxt = 1'b1;
        end
      end
      StInitLoad: begin
        w_ld_cycle = (r_cnt == 4'd0);
        if (32'(r_cnt) == SETTLE) begin
          w_cnt_nxt = '0;
          if (32'(r_lane) == W - 1) begin
            w_state_nxt     = StIdle;
            w_init_done_nxt = 1'b1;
          end else begin
            w_lane_nxt = r_lane + LW'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      StIdle: begin
        if (w_accept) begin
          w_lane_nxt = cmd_lane;
          w_tap_nxt  = cmd_tap;
          if (!w_lane_ok) begin
            w_state_nxt     = StResp;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_tap_nxt   = '0;
            w_rsp_err_nxt   = 1'b1;
          end else if (cmd_wr) begin
            w_state_nxt = StLoad;
          end else begin
            w_state_nxt     = StResp;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_tap_nxt   = w_out[cmd_lane];
            w_rsp_err_nxt   = 1'b0;
          end
        end
      end
      StLoad: begin
        w_ld_cycle = 1'b1;
        w_ld_val   = r_tap;
        // The CHECK cycle is the last of the SETTLE cycles after the LD pulse.
        if (SETTLE <= 1) begin
          w_state_nxt = StCheck;
        end else begin
          w_state_nxt = StSettle;
          w_cnt_nxt   = 4'd1;
        end
      end
      StSettle: begin
        if (32'(r_cnt) >= SETTLE - 1) w_state_nxt = StCheck;
        else                          w_cnt_nxt   = r_cnt + 4'd1;
      end
      StCheck: begin
        w_state_nxt     = StResp;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_tap_nxt   = w_out[r_lane];
        w_rsp_err_nxt   = (w_out[r_lane] != r_tap);
      end
      StResp: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_rsp_tap_nxt   = '0;
          w_rsp_err_nxt   = 1'b0;
          w_abort_nxt     = 1'b0;
          w_state_nxt     = (r_abort || !dlyctrl_rdy) ? StInitWait : StIdle;
        end
      end
      default: w_state_nxt = StInitWait;
    endcase

    // Losing IDELAYCTRL ready aborts everything; an in-flight write still gets a response.
    if (!dlyctrl_rdy && r_state != StInitWait) begin
      w_init_done_nxt = 1'b0;
      w_ld_cycle      = 1'b0;
      w_rdy_seen_nxt  = 1'b0;
      case (r_state)
        StLoad, StSettle, StCheck: begin
          w_state_nxt     = StResp;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_tap_nxt   = w_out[r_lane];
          w_rsp_err_nxt   = 1'b1;
          w_abort_nxt     = 1'b1;
        end
        StResp: begin
          if (!rsp_ready) w_abort_nxt = 1'b1;
        end
        default: w_state_nxt = StInitWait;
      endcase
    end
  end

  always_comb begin
    ld = w_ld_cycle ? (W'(1) << r_lane) : '0;
    for (int unsigned i = 0; i < W; i++) begin
      cntvaluein[i*TAPW +: TAPW] = (w_ld_cycle && 32'(r_lane) == i) ? w_ld_val : r_shadow[i];
    end
  end

  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) r_state <= StInitWait;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_rdy_seen  <= 1'b0;
      r_lane      <= '0;
      r_cnt       <= '0;
      r_tap       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_tap   <= '0;
      r_rsp_err   <= 1'b0;
      r_init_done <= 1'b0;
      r_abort     <= 1'b0;
      for (int unsigned i = 0; i < W; i++) r_shadow[i] <= '0;
    end else begin
      r_rdy_seen  <= w_rdy_seen_nxt;
      r_lane      <= w_lane_nxt;
      r_cnt       <= w_cnt_nxt;
      r_tap       <= w_tap_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_tap   <= w_rsp_tap_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_init_done <= w_init_done_nxt;
      r_abort     <= w_abort_nxt;
      if (w_ld_cycle) r_shadow[r_lane] <= w_ld_val;
    end
  end

endmodule

// File: tb/tb_dly_tap_ctrl.sv
// Directed bench for dly_tap_ctrl: a delay-element model latches CNTVALUEIN on LD and
// a response scoreboard checks tap, error flag, latency and LD activity per command.
module tb_dly_tap_ctrl;
  localparam int W      = 8;
  localparam int TAPW   = 5;
  localparam int SETTLE = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              dlyctrl_rdy = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_wr = 1'b0;
  logic [2:0]        cmd_lane = '0;
  logic [TAPW-1:0]   cmd_tap = '0;
  logic              rsp_ready = 1'b0;
  logic              cmd_ready, rsp_valid, rsp_err, init_done;
  logic [TAPW-1:0]   rsp_tap;
  logic [W-1:0]      ld;
  logic [W*TAPW-1:0] cntvaluein, cntvalueout;

  logic [TAPW-1:0]   m_out [W];
  logic              flip5 = 1'b0;
  int                cyc = 0;
  int                n_chk = 0;
  int                n_bad = 0;

  typedef struct {
    logic [TAPW-1:0] tap;
    logic            err;
    int              lat;
    int              nld;
    logic [W-1:0]    ldv;
  } exp_t;
  exp_t sb[$];

  dly_tap_ctrl #(.W(W), .TAPW(TAPW), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .dlyctrl_rdy(dlyctrl_rdy),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_wr     (cmd_wr),
    .cmd_lane   (cmd_lane),
    .cmd_tap    (cmd_tap),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_tap    (rsp_tap),
    .rsp_err    (rsp_err),
    .ld         (ld),
    .cntvaluein (cntvaluein),
    .cntvalueout(cntvalueout),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Delay-element model; lane 5 can be made to load a corrupted value.
  always @(negedge clk) begin
    for (int i = 0; i < W; i++) begin
      if (rst) m_out[i] <= '0;
      else if (ld[i]) m_out[i] <= cntvaluein[i*TAPW +: TAPW] ^ ((i == 5 && flip5) ? 5'd1 : 5'd0);
    end
  end

  for (genvar g = 0; g < W; g++) begin : g_out
    assign cntvalueout[g*TAPW +: TAPW] = m_out[g];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_init(input string tag);
    int r, n, first, last, bad_order, bad_space, done_cyc;
    logic [W-1:0] one;
    r = cyc; n = 0; first = -1; last = -1; bad_order = 0; bad_space = 0; done_cyc = -1;
    dlyctrl_rdy = 1'b1;
    for (int k = 0; k < 100 && done_cyc < 0; k++) begin
      tick();
      if (ld != '0) begin
        one = W'(1) << n;
        if (n == 0) first = cyc;
        else if (cyc - last != 1 + SETTLE) bad_space++;
        if (ld !== one) bad_order++;
        last = cyc;
        n++;
      end
      if (init_done === 1'b1) done_cyc = cyc;
    end
    chk({tag, "_ld_count"}, n, W);
    chk({tag, "_first_ld_delay"}, first - r, 2);
    chk({tag, "_ld_order"}, bad_order, 0);
    chk({tag, "_ld_spacing"}, bad_space, 0);
    chk({tag, "_done_delay"}, done_cyc - r, 2 + W * (1 + SETTLE));
    chk({tag, "_cntvaluein_zero"}, cntvaluein, 0);
  endtask

  task automatic send_cmd(input logic wr, input logic [2:0] lane, input logic [TAPW-1:0] tap,
                          input logic [TAPW-1:0] e_tap, input logic e_err, input int e_lat,
                          input int e_nld, input logic [W-1:0] e_ldv, output int t_acc);
    exp_t e;
    e.tap = e_tap; e.err = e_err; e.lat = e_lat; e.nld = e_nld; e.ldv = e_ldv;
    sb.push_back(e);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_lane = lane; cmd_tap = tap;
    for (int k = 0; k < 50 && cmd_ready !== 1'b1; k++) tick();
    chk("cmd_accept", cmd_ready, 1);
    t_acc = cyc;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int t_acc, input int drop_at);
    exp_t e;
    int nld, ldc;
    logic [W-1:0] ldv;
    nld = 0; ldc = -1; ldv = '0;
    for (int k = 0; k < 40 && rsp_valid !== 1'b1; k++) begin
      if (cyc - t_acc == drop_at) dlyctrl_rdy = 1'b0;
      if (ld != '0) begin
        nld++; ldv = ld; ldc = cyc;
      end
      tick();
    end
    chk("rsp_valid_seen", rsp_valid, 1);
    if (sb.size() > 0) e = sb.pop_front();
    else begin
      e.tap = 'x; e.err = 'x; e.lat = -1; e.nld = -1; e.ldv = 'x;
    end
    chk("rsp_latency", cyc - t_acc, e.lat);
    chk("rsp_tap", rsp_tap, e.tap);
    chk("rsp_err", rsp_err, e.err);
    chk("ld_pulses", nld, e.nld);
    if (e.nld > 0) begin
      chk("ld_value", ldv, e.ldv);
      chk("ld_cycle", ldc - t_acc, 1);
    end
  endtask

  task automatic ack(input int hold, input bit chk_cmd, output int hs);
    logic [TAPW-1:0] tap0;
    logic err0;
    int unstable, busy;
    tap0 = rsp_tap; err0 = rsp_err; unstable = 0; busy = 0;
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (rsp_valid !== 1'b1 || rsp_tap !== tap0 || rsp_err !== err0) unstable++;
      if (cmd_ready !== 1'b0) busy++;
      tick();
    end
    if (hold > 0) chk("hold_rsp_stable", unstable, 0);
    if (chk_cmd) begin
      chk("hold_cmd_ready_low", busy, 0);
      chk("hs_cmd_ready_low", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    hs = cyc;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_cleared", rsp_valid, 0);
  endtask

  initial begin
    int t, hs;
    repeat (3) tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_tap", rsp_tap, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_ld", ld, 0);
    chk("rst_cntvaluein", cntvaluein, 0);
    chk("rst_init_done", init_done, 0);
    rst = 1'b0;
    repeat (5) tick();
    chk("pre_rdy_init_done", init_done, 0);
    check_init("init");
    chk("idle_cmd_ready", cmd_ready, 1);

    send_cmd(1'b1, 3'd3, 5'd17, 5'd17, 1'b0, 2 + SETTLE, 1, 8'h08, t);
    wait_rsp(t, -1);
    chk("shadow_lane3", cntvaluein[15 +: 5], 17);
    ack(0, 1'b0, hs);

    flip5 = 1'b1;
    send_cmd(1'b1, 3'd5, 5'd9, 5'd8, 1'b1, 2 + SETTLE, 1, 8'h20, t);
    wait_rsp(t, -1);
    chk("shadow_lane5", cntvaluein[25 +: 5], 9);
    ack(0, 1'b0, hs);
    flip5 = 1'b0;

    send_cmd(1'b0, 3'd3, 5'd0, 5'd17, 1'b0, 1, 0, 8'h00, t);
    wait_rsp(t, -1);
    ack(0, 1'b0, hs);

    send_cmd(1'b0, 3'd5, 5'd0, 5'd8, 1'b0, 1, 0, 8'h00, t);
    wait_rsp(t, -1);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_lane = 3'd0;
    ack(10, 1'b1, hs);
    send_cmd(1'b0, 3'd0, 5'd0, 5'd0, 1'b0, 1, 0, 8'h00, t);
    chk("accept_after_hs", t - hs, 1);
    wait_rsp(t, -1);
    ack(0, 1'b0, hs);

    send_cmd(1'b1, 3'd2, 5'd21, 5'd21, 1'b1, 3, 1, 8'h04, t);
    wait_rsp(t, 2);
    chk("drop_init_done", init_done, 0);
    ack(0, 1'b0, hs);
    repeat (3) tick();
    chk("drop_cmd_ready", cmd_ready, 0);
    chk("drop_shadow_lane2", cntvaluein[10 +: 5], 21);
    check_init("reload");
    chk("reload_init_done", init_done, 1);

    send_cmd(1'b0, 3'd3, 5'd0, 5'd0, 1'b0, 1, 0, 8'h00, t);
    wait_rsp(t, -1);
    ack(0, 1'b0, hs);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
